// File: rtl/tri_raster_stream_if.sv
// Vertex-in / fragment-out handshake bundle for tri_raster_stream.
// slave = rasterizer side, master = geometry / framebuffer side.
interface tri_raster_stream_if #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned COLOR_W = 64,
  parameter int unsigned ADDR_W  = 18
);
  logic                      I_VTX_VALID;
  logic                      O_VTX_READY;
  logic signed [COORD_W-1:0] I_VTX_X;
  logic signed [COORD_W-1:0] I_VTX_Y;
  logic        [COLOR_W-1:0] I_VTX_COLOR;
  logic                      O_FRAG_VALID;
  logic                      I_FRAG_READY;
  logic        [ADDR_W-1:0]  O_FRAG_ADDR;
  logic        [COLOR_W-1:0] O_FRAG_COLOR;
  logic                      O_BUSY;
  logic                      O_DONE;

  modport slave (
    input  I_VTX_VALID, I_VTX_X, I_VTX_Y, I_VTX_COLOR, I_FRAG_READY,
    output O_VTX_READY, O_FRAG_VALID, O_FRAG_ADDR, O_FRAG_COLOR, O_BUSY, O_DONE
  );

  modport master (
    output I_VTX_VALID, I_VTX_X, I_VTX_Y, I_VTX_COLOR, I_FRAG_READY,
    input  O_VTX_READY, O_FRAG_VALID, O_FRAG_ADDR, O_FRAG_COLOR, O_BUSY, O_DONE
  );
endinterface

// File: rtl/tri_raster_stream.sv
// Single-triangle edge-function rasterizer emitting flat-shaded fragments in raster order.
// Optional macro RAST_BACKFACE_CULL_EN: negative-area triangles are culled instead of flipped.
module tri_raster_stream #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 400,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned COLOR_W  = 64,
  parameter int unsigned ADDR_W   = 18
) (
  input logic I_CLOCK,
  input logic I_RESET,
  tri_raster_stream_if.slave bus
);
  localparam int unsigned EW = 2*COORD_W + 2;
  localparam int unsigned XW = COORD_W + 1;
  localparam logic signed [XW-1:0] X_LIM = $signed(XW'(SCREEN_W - 1));
  localparam logic signed [XW-1:0] Y_LIM = $signed(XW'(SCREEN_H - 1));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_BBOX  = 3'd2;
  localparam logic [2:0] S_ROW   = 3'd3;
  localparam logic [2:0] S_SCAN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic signed [COORD_W-1:0] vx_q [3], vx_d [3];
  logic signed [COORD_W-1:0] vy_q [3], vy_d [3];
  logic [COLOR_W-1:0]        col_q, col_d;
  logic signed [EW-1:0]      a_q [3], a_d [3];
  logic signed [EW-1:0]      b_q [3], b_d [3];
  logic signed [EW-1:0]      c_q [3], c_d [3];
  logic signed [EW-1:0]      e_q [3], e_d [3];
  logic [COORD_W-1:0]        xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0]        ymax_q, ymax_d;
  logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
  logic                      rdy_q, rdy_d, fv_q, fv_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]         fa_q, fa_d;
  logic [COLOR_W-1:0]        fc_q, fc_d;

  logic signed [EW-1:0]      xs [3], ys [3];
  logic signed [EW-1:0]      sa [3], sb [3], sc [3];
  logic signed [EW-1:0]      area;
  logic signed [COORD_W-1:0] mnx, mxx, mny, mxy;
  logic signed [XW-1:0]      lo_x, hi_x, lo_y, hi_y;
  logic                      bb_empty, cov, slot_free;

  // Edge coefficients and doubled signed area from the stored vertices.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      xs[k] = EW'(vx_q[k]);
      ys[k] = EW'(vy_q[k]);
    end
    sa[0] = ys[1] - ys[2]; sb[0] = xs[2] - xs[1]; sc[0] = xs[1]*ys[2] - xs[2]*ys[1];
    sa[1] = ys[2] - ys[0]; sb[1] = xs[0] - xs[2]; sc[1] = xs[2]*ys[0] - xs[0]*ys[2];
    sa[2] = ys[0] - ys[1]; sb[2] = xs[1] - xs[0]; sc[2] = xs[0]*ys[1] - xs[1]*ys[0];
    area  = sa[0]*xs[0] + sb[0]*ys[0] + sc[0];
  end

  // Bounding box clipped to the frame.
  always_comb begin
    mnx = vx_q[0]; mxx = vx_q[0]; mny = vy_q[0]; mxy = vy_q[0];
    for (int k = 1; k < 3; k++) begin
      if (vx_q[k] < mnx) mnx = vx_q[k];
      if (vx_q[k] > mxx) mxx = vx_q[k];
      if (vy_q[k] < mny) mny = vy_q[k];
      if (vy_q[k] > mxy) mxy = vy_q[k];
    end
    lo_x = XW'(mnx); hi_x = XW'(mxx); lo_y = XW'(mny); hi_y = XW'(mxy);
    if (lo_x[XW-1]) lo_x = '0;
    if (lo_y[XW-1]) lo_y = '0;
    if (hi_x > X_LIM) hi_x = X_LIM;
    if (hi_y > Y_LIM) hi_y = Y_LIM;
    bb_empty = (lo_x > hi_x) || (lo_y > hi_y);
  end

  // Coverage with top-left tie breaking on pixels exactly on an edge.
  always_comb begin
    cov = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!((!e_q[k][EW-1] && (e_q[k] != '0)) ||
            ((e_q[k] == '0) &&
             ((!a_q[k][EW-1] && (a_q[k] != '0)) ||
              ((a_q[k] == '0) && !b_q[k][EW-1] && (b_q[k] != '0))))))
        cov = 1'b0;
    end
  end

  assign slot_free = !fv_q || bus.I_FRAG_READY;

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; vx_d = vx_q; vy_d = vy_q; col_d = col_q;
    a_d = a_q; b_d = b_q; c_d = c_q; e_d = e_q;
    xmin_d = xmin_q; xmax_d = xmax_q; ymax_d = ymax_q; x_d = x_q; y_d = y_q;
    busy_d = busy_q; done_d = 1'b0;
    fv_d = fv_q; fa_d = fa_q; fc_d = fc_q;

    if (fv_q && bus.I_FRAG_READY) begin
      fv_d = 1'b0; fa_d = '0; fc_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.I_VTX_VALID && rdy_q) begin
          vx_d[cnt_q] = bus.I_VTX_X;
          vy_d[cnt_q] = bus.I_VTX_Y;
          if (cnt_q == 2'd0) col_d = bus.I_VTX_COLOR;
          if (cnt_q == 2'd2) begin
            cnt_d = 2'd0; busy_d = 1'b1; state_d = S_SETUP;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_SETUP: begin
        for (int k = 0; k < 3; k++) begin
          a_d[k] = area[EW-1] ? -sa[k] : sa[k];
          b_d[k] = area[EW-1] ? -sb[k] : sb[k];
          c_d[k] = area[EW-1] ? -sc[k] : sc[k];
        end
`ifdef RAST_BACKFACE_CULL_EN
        state_d = (area == '0 || area[EW-1]) ? S_DONE : S_BBOX;
`else
        state_d = (area == '0) ? S_DONE : S_BBOX;
`endif
      end
      S_BBOX: begin
        xmin_d = COORD_W'(lo_x);
        xmax_d = COORD_W'(hi_x);
        ymax_d = COORD_W'(hi_y);
        y_d    = COORD_W'(lo_y);
        state_d = bb_empty ? S_DONE : S_ROW;
      end
      S_ROW: begin
        for (int k = 0; k < 3; k++)
          e_d[k] = a_q[k]*$signed(EW'(xmin_q)) + b_q[k]*$signed(EW'(y_q)) + c_q[k];
        x_d = xmin_q;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (slot_free) begin
          if (cov) begin
            fv_d = 1'b1;
            fa_d = ADDR_W'(y_q)*ADDR_W'(SCREEN_W) + ADDR_W'(x_q);
            fc_d = col_q;
          end
          if (x_q == xmax_q) begin
            if (y_q < ymax_q) begin
              y_d = y_q + COORD_W'(1); state_d = S_ROW;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            x_d = x_q + COORD_W'(1);
            for (int k = 0; k < 3; k++) e_d[k] = e_q[k] + a_q[k];
          end
        end
      end
      S_DONE: begin
        if (!fv_q) begin
          done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q <= S_IDLE; cnt_q <= '0; col_q <= '0;
      for (int k = 0; k < 3; k++) begin
        vx_q[k] <= '0; vy_q[k] <= '0;
        a_q[k] <= '0; b_q[k] <= '0; c_q[k] <= '0; e_q[k] <= '0;
      end
      xmin_q <= '0; xmax_q <= '0; ymax_q <= '0; x_q <= '0; y_q <= '0;
      rdy_q <= 1'b0; fv_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
      fa_q <= '0; fc_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; col_q <= col_d;
      vx_q <= vx_d; vy_q <= vy_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; e_q <= e_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymax_q <= ymax_d; x_q <= x_d; y_q <= y_d;
      rdy_q <= rdy_d; fv_q <= fv_d; busy_q <= busy_d; done_q <= done_d;
      fa_q <= fa_d; fc_q <= fc_d;
    end
  end

  assign bus.O_VTX_READY  = rdy_q;
  assign bus.O_FRAG_VALID = fv_q;
  assign bus.O_FRAG_ADDR  = fa_q;
  assign bus.O_FRAG_COLOR = fc_q;
  assign bus.O_BUSY       = busy_q;
  assign bus.O_DONE       = done_q;
endmodule

// File: tb/tb_tri_raster_stream.sv
// Directed bench for tri_raster_stream on a 16x8 frame with hand-computed fragment lists.
module tb_tri_raster_stream;
  localparam int unsigned SW = 16;
  localparam int unsigned SH = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned KW = 64;
  localparam int unsigned AW = 7;
  localparam logic [63:0] COL0 = 64'hA5;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   q_addr [$];
  logic [63:0] q_col [$];
  int   exp1 [$];
  int   exp_big [$];
  int   lat, dc;

  tri_raster_stream_if #(.COORD_W(CW), .COLOR_W(KW), .ADDR_W(AW)) bus ();

  tri_raster_stream #(
    .SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW), .COLOR_W(KW), .ADDR_W(AW)
  ) dut (
    .I_CLOCK(clk),
    .I_RESET(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
    int xv [3];
    int yv [3];
    logic [63:0] cv [3];
    logic hs;
    int n;
    xv[0] = x0; xv[1] = x1; xv[2] = x2;
    yv[0] = y0; yv[1] = y1; yv[2] = y2;
    cv[0] = COL0; cv[1] = 64'h11; cv[2] = 64'h22;
    for (int v = 0; v < 3; v++) begin
      bus.I_VTX_VALID = 1'b1;
      bus.I_VTX_X     = CW'(xv[v]);
      bus.I_VTX_Y     = CW'(yv[v]);
      bus.I_VTX_COLOR = cv[v];
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 50) begin
        hs = bus.O_VTX_READY;
        tick();
        n++;
      end
      check("vtx_accept", 64'(hs), 64'd1);
    end
    bus.I_VTX_VALID = 1'b0;
  endtask

  // Drains one triangle; cycle count restarts at the third vertex handshake.
  task automatic run_tri(input int stall_n, input int stop_after,
                         output int lat_o, output int done_o);
    int cyc;
    int stall;
    bit seen;
    q_addr.delete();
    q_col.delete();
    lat_o = -1; done_o = -1; cyc = 0; stall = 0; seen = 1'b0;
    while (cyc < 2000) begin
      if (!seen && bus.O_FRAG_VALID) begin
        seen = 1'b1; lat_o = cyc; stall = stall_n;
      end
      if (stall > 0) begin
        bus.I_FRAG_READY = 1'b0;
        check("stall_valid", 64'(bus.O_FRAG_VALID), 64'd1);
        check("stall_addr",  64'(bus.O_FRAG_ADDR),  64'd0);
        check("stall_color", bus.O_FRAG_COLOR,      COL0);
        stall--;
      end else begin
        bus.I_FRAG_READY = 1'b1;
      end
      if (cyc == 1) begin
        check("busy_after_accept",  64'(bus.O_BUSY),      64'd1);
        check("no_ready_when_busy", 64'(bus.O_VTX_READY), 64'd0);
      end
      if (bus.O_FRAG_VALID && bus.I_FRAG_READY) begin
        q_addr.push_back(int'(bus.O_FRAG_ADDR));
        q_col.push_back(bus.O_FRAG_COLOR);
      end
      tick();
      cyc++;
      if (bus.O_DONE) begin
        done_o = cyc;
        break;
      end
      if (stop_after > 0 && q_addr.size() >= stop_after) break;
    end
  endtask

  task automatic check_seq(input string tag, input int exp_a [$]);
    check({tag, "_count"}, 64'(q_addr.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < q_addr.size(); i++) begin
      check({tag, "_addr"},  64'(q_addr[i]), 64'(exp_a[i]));
      check({tag, "_color"}, q_col[i],       COL0);
    end
  endtask

  task automatic check_after_done(input string tag, input int done_cyc);
    check({tag, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
    check({tag, "_busy_low"},  64'(bus.O_BUSY),   64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(bus.O_DONE), 64'd0);
    check({tag, "_ready_idle"}, 64'(bus.O_VTX_READY), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vtx_ready"},  64'(bus.O_VTX_READY),  64'd0);
    check({tag, "_frag_valid"}, 64'(bus.O_FRAG_VALID), 64'd0);
    check({tag, "_frag_addr"},  64'(bus.O_FRAG_ADDR),  64'd0);
    check({tag, "_frag_color"}, bus.O_FRAG_COLOR,      64'd0);
    check({tag, "_busy"},       64'(bus.O_BUSY),       64'd0);
    check({tag, "_done"},       64'(bus.O_DONE),       64'd0);
  endtask

  initial begin
    exp1 = '{0, 1, 2, 3, 16, 17, 18, 32, 33, 48};
    for (int y = 0; y < 8; y++)
      for (int x = 0; x <= 15 - y; x++)
        exp_big.push_back(y*16 + x);

    rst = 1'b1;
    bus.I_VTX_VALID = 1'b0; bus.I_VTX_X = '0; bus.I_VTX_Y = '0;
    bus.I_VTX_COLOR = '0;   bus.I_FRAG_READY = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset", 64'(bus.O_VTX_READY), 64'd1);

    // Small right triangle: latency, order, colour.
    send_tri(0, 0, 4, 0, 0, 4);
    run_tri(0, 0, lat, dc);
    check("t1_latency", 64'(lat), 64'd4);
    check_seq("t1", exp1);
    check_after_done("t1", dc);

    // Same triangle with clockwise winding.
    send_tri(0, 0, 0, 4, 4, 0);
    run_tri(0, 0, lat, dc);
`ifdef RAST_BACKFACE_CULL_EN
    check("t2_cull_count", 64'(q_addr.size()), 64'd0);
`else
    check_seq("t2", exp1);
`endif
    check_after_done("t2", dc);

    // Oversized triangle clipped by the frame.
    send_tri(-4, -4, 20, -4, -4, 20);
    run_tri(0, 0, lat, dc);
    check_seq("t3", exp_big);
    check_after_done("t3", dc);

    // Fully off-screen.
    send_tri(-10, -10, -5, -10, -10, -5);
    run_tri(0, 0, lat, dc);
    check("t4_count", 64'(q_addr.size()), 64'd0);
    check("t4_done_lat", 64'(dc >= 1 && dc <= 3), 64'd1);
    check_after_done("t4", dc);

    // Degenerate (collinear).
    send_tri(1, 1, 2, 2, 3, 3);
    run_tri(0, 0, lat, dc);
    check("t5_count", 64'(q_addr.size()), 64'd0);
    check("t5_done_lat", 64'(dc >= 1 && dc <= 3), 64'd1);
    check_after_done("t5", dc);

    // Back-pressure on the first fragment.
    send_tri(0, 0, 4, 0, 0, 4);
    run_tri(5, 0, lat, dc);
    check_seq("t6", exp1);
    check_after_done("t6", dc);

    // Reset after the third accepted fragment.
    send_tri(0, 0, 4, 0, 0, 4);
    run_tri(0, 3, lat, dc);
    check("t7_pre_count", 64'(q_addr.size()), 64'd3);
    rst = 1'b1;
    tick();
    check_reset_outputs("t7_reset");
    rst = 1'b0;
    tick();
    check("t7_no_done", 64'(bus.O_DONE), 64'd0);
    check("t7_ready",   64'(bus.O_VTX_READY), 64'd1);
    send_tri(0, 0, 4, 0, 0, 4);
    run_tri(0, 0, lat, dc);
    check("t7_latency", 64'(lat), 64'd4);
    check_seq("t7", exp1);
    check_after_done("t7", dc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
